// File: rtl/ram_ctrl_pkg.sv
// Shared types and default geometry for the 512x16 RAM request controller.
package ram_ctrl_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/ram_addr_gen.sv
// Burst address/beat counter: loads start address and beats-minus-one,
// steps both per committed beat; the address wraps modulo 2^ADDR_W.
module ram_addr_gen #(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else if (load) begin
      addr_q   <= load_addr;
      remain_q <= load_len;
    end else if (step) begin
      addr_q   <= addr_q + ADDR_W'(1);
      remain_q <= remain_q - LEN_W'(1);
    end
  end

  assign addr = addr_q;
  assign last = (remain_q == '0);
endmodule

// File: rtl/ram_512_initiator.sv
// Request-side controller for RAM_512: single/burst reads and writes over
// valid/ready, with a registered, back-pressurable read response.
//
//   state | meaning
//   IDLE  | ready for a request, RAM disabled
//   WRITE | one write beat per cycle while wd_valid is high
//   READ  | RAM read cycle, ram_out captured at the closing edge
//   RESP  | read word presented, held until rsp_ready
module ram_512_initiator #(
  parameter int ADDR_W = ram_ctrl_pkg::ADDR_W,
  parameter int DATA_W = ram_ctrl_pkg::DATA_W,
  parameter int LEN_W  = ram_ctrl_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              ram_e,
  output logic              ram_w,
  output logic              ram_r,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_out
);
  import ram_ctrl_pkg::*;

  state_t            state_q, state_d;
  logic              ag_load, ag_step, ag_last;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_last_q;

  ram_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ag_load),
    .step      (ag_step),
    .load_addr (req_addr),
    .load_len  (req_len),
    .addr      (addr),
    .last      (ag_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // ram_out is only defined during READ, so capture strictly there
      if (state_q == READ) begin
        rsp_data_q <= ram_out;
        rsp_last_q <= ag_last;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ag_load = 1'b0;
    ag_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          ag_load = 1'b1;
          state_d = req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wd_valid) begin
          ag_step = 1'b1;
          if (ag_last) state_d = IDLE;
        end
      end
      READ: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            ag_step = 1'b1;
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wd_ready  = (state_q == WRITE);
  assign ram_w     = (state_q == WRITE) && wd_valid;
  assign ram_r     = (state_q == READ);
  assign ram_e     = (state_q == WRITE) || (state_q == READ);
  assign ram_addr  = addr;
  assign ram_d     = wd_data;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
endmodule

// File: tb/tb_ram_512_initiator.sv
// Self-checking bench for ram_512_initiator: behavioural RAM plus a
// transaction-level golden memory, directed scenarios and random bursts.
module tb_ram_512_initiator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [8:0]  req_addr;
  logic [3:0]  req_len;
  logic        wd_valid, wd_ready;
  logic [15:0] wd_data;
  logic        rsp_valid, rsp_ready, rsp_last, busy;
  logic [15:0] rsp_data;
  logic        ram_e, ram_w, ram_r;
  logic [8:0]  ram_addr;
  logic [15:0] ram_d, ram_out;

  logic [15:0] mem  [512];
  logic [15:0] gold [512];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_512_initiator dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy),
    .ram_e(ram_e), .ram_w(ram_w), .ram_r(ram_r),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_out(ram_out)
  );

  always @(posedge clk) if (ram_e && ram_w) mem[ram_addr] <= ram_d;
  assign ram_out = ram_r ? mem[ram_addr] : 'x;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int c = 0; c < 100 && !req_ready; c++) tick();
    check("req_ready_wait", req_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ram_e"}, ram_e, 0);
    check({tag, "_ram_w"}, ram_w, 0);
    check({tag, "_ram_r"}, ram_r, 0);
    check({tag, "_wd_ready"}, wd_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_last"}, rsp_last, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_d"}, ram_d, wd_data);
  endtask

  // seq=1: data base+i, otherwise random; hold=1 keeps req_valid up with a
  // read request for address na (len 0) during the burst.
  task automatic do_write(input int a, input int len, input bit seq, input logic [15:0] base,
                          input int stall_at, input int stall_n, input bit hold, input int na);
    logic [15:0] d;
    wait_ready();
    req_valid = 1; req_we = 1; req_addr = 9'(a); req_len = 4'(len);
    tick();
    if (hold) begin
      req_we = 0; req_addr = 9'(na); req_len = 0;
    end else begin
      req_valid = 0;
    end
    for (int i = 0; i <= len; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          wd_valid = 0; wd_data = 16'($urandom);
          #1;
          check("stall_ram_w", ram_w, 0);
          check("stall_addr", ram_addr, (a + i) % 512);
          tick();
        end
      end
      d = seq ? 16'(base + 16'(i)) : 16'($urandom);
      wd_valid = 1; wd_data = d;
      #1;
      check("wr_ram_w", ram_w, 1);
      check("wr_ram_e", ram_e, 1);
      check("wr_wd_ready", wd_ready, 1);
      check("wr_addr", ram_addr, (a + i) % 512);
      check("wr_ram_d", ram_d, d);
      check("wr_req_ready", req_ready, 0);
      tick();
      gold[(a + i) % 512] = d;
    end
    wd_valid = 0;
    #1;
    check("wr_busy_after", busy, 0);
  endtask

  task automatic do_read(input int a, input int len, input int bp_beat, input int bp_n);
    wait_ready();
    req_valid = 1; req_we = 0; req_addr = 9'(a); req_len = 4'(len);
    tick();
    req_valid = 0;
    for (int i = 0; i <= len; i++) begin
      check("rd_ram_r", ram_r, 1);
      check("rd_ram_e", ram_e, 1);
      check("rd_addr", ram_addr, (a + i) % 512);
      check("rd_rsp_valid_lo", rsp_valid, 0);
      tick();
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, gold[(a + i) % 512]);
      check("rsp_last", rsp_last, (i == len) ? 1 : 0);
      check("rsp_ram_r", ram_r, 0);
      check("rsp_ram_e", ram_e, 0);
      if (i == bp_beat) begin
        for (int s = 0; s < bp_n; s++) begin
          rsp_ready = 0;
          tick();
          check("bp_rsp_valid", rsp_valid, 1);
          check("bp_rsp_data", rsp_data, gold[(a + i) % 512]);
          check("bp_ram_r", ram_r, 0);
        end
      end
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
    end
    #1;
    check("rd_busy_after", busy, 0);
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_len = 0;
    wd_valid = 0; wd_data = 16'h1234; rsp_ready = 0;
    for (int i = 0; i < 512; i++) begin
      mem[i]  = 16'($urandom);
      gold[i] = mem[i];
    end
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1;
    tick();

    do_write(37, 0, 1, 16'hA5A5, 99, 0, 0, 0);
    check("mem37", mem[37], 16'hA5A5);
    do_read(37, 0, 99, 0);

    do_write(510, 3, 1, 16'd1, 99, 0, 0, 0);
    check("wrap510", mem[510], 1);
    check("wrap511", mem[511], 2);
    check("wrap0", mem[0], 3);
    check("wrap1", mem[1], 4);
    do_read(510, 3, 99, 0);

    do_write(100, 2, 0, 0, 99, 0, 0, 0);
    do_read(100, 2, 1, 5);

    do_write(200, 5, 1, 16'h0200, 3, 3, 0, 0);
    for (int i = 0; i < 6; i++) check("stall_mem", mem[200 + i], 16'h0200 + 16'(i));
    do_read(200, 5, 99, 0);

    do_write(300, 2, 0, 0, 99, 0, 1, 37);
    check("held_req_ready", req_ready, 1);
    do_read(37, 0, 99, 0);
    tick();
    check("held_once_busy", busy, 0);

    for (int t = 0; t < 30; t++) begin
      int a, len;
      a = $urandom_range(0, 511);
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1)
        do_write(a, len, 0, 0, $urandom_range(0, len + 3), $urandom_range(1, 3), 0, 0);
      else
        do_read(a, len, $urandom_range(0, len + 3), $urandom_range(1, 4));
    end

    // reset mid-burst: two of eight beats committed, third aborted by reset
    wait_ready();
    req_valid = 1; req_we = 1; req_addr = 9'd400; req_len = 4'd7;
    tick();
    req_valid = 0;
    for (int i = 0; i < 2; i++) begin
      wd_valid = 1; wd_data = 16'hC000 + 16'(i);
      tick();
      gold[400 + i] = 16'hC000 + 16'(i);
    end
    wd_data = 16'hDEAD;
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("midrst");
    wd_valid = 0;
    tick();
    @(negedge clk);
    rst_n = 1;
    tick();
    for (int i = 0; i < 8; i++) check("midrst_mem", mem[400 + i], gold[400 + i]);
    do_read(400, 7, 99, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
